hack_ram_ctl: RTL
=================

# hack_ram_ctl

Parametrised single-port synchronous RAM for the Hack CPU data path, generalising the fixed 16-bit × 8K RAM. Width, depth, read-during-write mode and output pipelining are set by parameters. A built-in clear sequencer fills the array with a constant after reset or on request. Sits between the CPU memory-mapping logic and the block RAM primitive. Read data carries a valid strobe so the CPU need not hard-code read latency.

## Interface
- WIDTH, 16, data word width in bits
- ADDR_W, 13, address width; DEPTH = 2**ADDR_W words (default 8192)
- RDW_MODE, 0, read-during-write behaviour: 0 = NO_CHANGE (out holds), 1 = WRITE_FIRST (out = in), 2 = READ_FIRST (out = old word)
- OUT_REG, 0, 1 adds an output pipeline register (read latency 2 instead of 1)
- CLEAR_ON_RESET, 1, 1 runs the clear sequencer automatically after reset release
- CLEAR_VAL, 0, WIDTH-bit value written by the clear sequencer

Ports:
- clk  in  1  rising-edge clock, sole clock domain
- rst_n  in  1  asynchronous active-low reset
- in  in  WIDTH  write data
- load  in  1  write enable; write mem[address] <= in at clk edge
- address  in  ADDR_W  word address, all values valid
- clear  in  1  single-cycle request to start the clear sequence
- out  out  WIDTH  read data
- out_valid  out  1  high for one cycle when out carries the result of an accepted operation
- busy  out  1  high while the clear sequencer owns the array

## Operation
- FSM states: IDLE, CLEAR.
- Reset state is CLEAR when CLEAR_ON_RESET=1; otherwise IDLE. Clear address counter resets to 0.
- IDLE:
  - load=1: write in to mem[address].
  - load=0: read mem[address].
  - clear=1: go to CLEAR with counter 0. If load=1 on the same cycle, the write is still performed.
- An operation is accepted in IDLE when load=0, or when load=1 and RDW_MODE≠0. Each accepted operation produces exactly one out_valid pulse.
- Write cycle output by mode:
  - NO_CHANGE: out holds its previous value; no out_valid.
  - WRITE_FIRST: out = in.
  - READ_FIRST: out = the old word at that address.
- CLEAR:
  - Each cycle writes CLEAR_VAL to mem[counter], then counter+1.
  - After writing address DEPTH-1, return to IDLE. The counter wraps to 0 and is not reused.
  - busy=1 throughout CLEAR.
  - load is ignored; no write from the port, no reads accepted, no out_valid.
  - clear requests in CLEAR are ignored; the sequence is not restarted.
  - out holds its value.
- Array contents are not affected by rst_n; only the sequencer initialises them.

## Timing
- Reset values:
  - out = 0
  - out_valid = 0
  - busy = CLEAR_ON_RESET
  - internal pipeline register = 0
- OUT_REG=0: out and out_valid update at the edge that samples the operation (latency 1).
- OUT_REG=1: out and out_valid update one edge later (latency 2). Back-to-back reads give one result per cycle, in order.
- Clear after reset:
  - First write (address 0) happens at the first rising edge after rst_n deasserts.
  - busy falls after edge DEPTH; the port is usable from the following edge.
- Clear on request:
  - The clear pulse is sampled at edge N; busy rises after edge N.
  - Address 0 is written at edge N+1; busy falls after edge N+DEPTH.
  - Total busy time is DEPTH cycles.
- Operations already in the OUT_REG pipeline when CLEAR starts still complete and pulse out_valid.
- rst_n asserted mid-clear or mid-read:
  - Outputs go immediately to reset values and the pipeline is flushed.
  - With CLEAR_ON_RESET=1, the clear restarts from address 0 after release.
  - With CLEAR_ON_RESET=0, the partial clear is abandoned; unwritten words keep their old contents.
- Write followed immediately by a read of the same address returns the new data.

## Test plan
- Reset clear (ADDR_W=4, CLEAR_VAL=16'hA5A5) -> busy=1 for exactly 16 cycles after release; reads of addresses 0..15 all return 16'hA5A5.
- Write/read (defaults, CLEAR_ON_RESET=0):
  - Stimulus: write 16'h1234 @ 13'h1FFF, then read 13'h1FFF, OUT_REG=0.
  - Response: out=16'h1234 with out_valid one edge after the read.
  - With OUT_REG=1, the same result arrives two edges after the read.
- RDW modes, mem[5]=16'h0001, then write 16'h0002 @5:
  - NO_CHANGE: out holds, out_valid=0.
  - WRITE_FIRST: out=16'h0002, out_valid=1.
  - READ_FIRST: out=16'h0001, out_valid=1.
- load during clear (ADDR_W=4): pulse clear, then assert load with 16'hFFFF @3 while busy -> ignored; after busy falls, read 3 returns CLEAR_VAL; no out_valid while busy.
- Streaming reads (OUT_REG=1): read addresses 0,1,2,3 back-to-back holding 10,11,12,13 -> out=10,11,12,13 on four consecutive cycles with out_valid held high.
- Reset mid-clear (ADDR_W=4, CLEAR_ON_RESET=1): assert rst_n low at clear step 7 -> out=0, busy=1 during reset; after release busy lasts 16 full cycles.

Source files
------------

// File: rtl/hack_ram_ctl.sv
// rtl/hack_ram_ctl.sv - parametrised Hack data RAM with clear sequencer and valid-strobed reads
//
// Single-port synchronous RAM for the Hack CPU data path. A clear sequencer
// fills the array with CLEAR_VAL after reset (CLEAR_ON_RESET=1) or on a
// clear pulse. Read results carry out_valid so the CPU need not assume a
// fixed latency (1 edge, or 2 with OUT_REG=1).
//
// Ports:
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset (array contents untouched)
//   in        in   [WIDTH]  write data
//   load      in   write enable; otherwise the cycle is a read
//   address   in   [ADDR_W] word address
//   clear     in   single-cycle request to start the clear sequence
//   out       out  [WIDTH]  read data (holds between results)
//   out_valid out  one pulse per accepted operation
//   busy      out  high while the clear sequencer owns the array
module hack_ram_ctl #(
  parameter int               WIDTH          = 16,
  parameter int               ADDR_W         = 13,
  parameter int               RDW_MODE       = 0,
  parameter int               OUT_REG        = 0,
  parameter bit               CLEAR_ON_RESET = 1'b1,
  parameter logic [WIDTH-1:0] CLEAR_VAL      = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WIDTH-1:0]  in,
  input  logic              load,
  input  logic [ADDR_W-1:0] address,
  input  logic              clear,
  output logic [WIDTH-1:0]  out,
  output logic              out_valid,
  output logic              busy
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {IDLE, CLEAR} state_t;

  localparam state_t RESET_STATE = CLEAR_ON_RESET ? CLEAR : IDLE;

  state_t             state;
  state_t             state_nxt;
  logic [ADDR_W-1:0]  clr_addr;
  logic               clr_last;

  logic               mem_we;
  logic [ADDR_W-1:0]  mem_waddr;
  logic [WIDTH-1:0]   mem_wdata;
  logic [WIDTH-1:0]   mem [DEPTH];
  logic [WIDTH-1:0]   rd_word;

  logic               accept;
  logic [WIDTH-1:0]   op_data;

  logic [WIDTH-1:0]   s1_data;
  logic               s1_valid;

  // Asynchronous read of the addressed word: it is the old contents during a
  // write cycle, which is exactly what READ_FIRST returns.
  assign rd_word  = mem[address];
  assign clr_last = &clr_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RESET_STATE;
      clr_addr <= '0;
    end else begin
      state <= state_nxt;
      // Counter only advances while clearing; it wraps to 0 after the last
      // word, so a fresh clear always starts at address 0.
      if (state == CLEAR) begin
        clr_addr <= clr_addr + ADDR_W'(1);
      end else begin
        clr_addr <= '0;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    mem_we    = 1'b0;
    mem_waddr = address;
    mem_wdata = in;
    accept    = 1'b0;
    busy      = 1'b0;
    op_data   = rd_word;
    case (state)
      IDLE: begin
        mem_we = load;
        // NO_CHANGE writes produce no result, every other cycle does.
        accept = !load || (RDW_MODE != 0);
        if (load && (RDW_MODE == 1)) begin
          op_data = in;
        end
        if (clear) begin
          state_nxt = CLEAR;
        end
      end
      CLEAR: begin
        busy      = 1'b1;
        mem_we    = 1'b1;
        mem_waddr = clr_addr;
        mem_wdata = CLEAR_VAL;
        if (clr_last) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = RESET_STATE;
      end
    endcase
  end

  // Storage has no reset: only the clear sequencer initialises it.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // First result stage: captured at the edge that samples the operation and
  // held otherwise, so out keeps its value across writes and clears.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_data  <= '0;
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_data <= op_data;
      end
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [WIDTH-1:0] out_q;
      logic             valid_q;

      // Runs regardless of FSM state so results in flight when a clear
      // starts still emerge.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          out_q   <= '0;
          valid_q <= 1'b0;
        end else begin
          valid_q <= s1_valid;
          if (s1_valid) begin
            out_q <= s1_data;
          end
        end
      end

      assign out       = out_q;
      assign out_valid = valid_q;
    end else begin : g_no_out_reg
      assign out       = s1_data;
      assign out_valid = s1_valid;
    end
  endgenerate

endmodule
